sram_loader: RTL and testbench
==============================

# sram_loader

Upstream feeder for the accelerator's input and weight SRAM write port. Accepts a narrow valid/ready element stream, packs elements LSB-first into SRAM_DATA_WIDTH words according to the precision mode, and issues single-cycle writes at auto-incrementing addresses. It reports the last written address so the route-stage end address (input address end) can be programmed without host arithmetic.

## Interface
- SRAM_DATA_WIDTH, 64, packed word width; must be a multiple of 8
- ADDR_WIDTH, 8, SRAM address width
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  job start pulse; sampled only in IDLE
- i_sram_select  in  2  target SRAM (0 weight, 1 input); latched at start
- i_base_addr  in  ADDR_WIDTH  first write address; latched at start
- i_word_count  in  ADDR_WIDTH+1  words to write; latched at start
- i_p_mode  in  2  element width: 00=8b, 01=4b, 10=2b, 11=treated as 00; latched at start
- i_data  in  8  element; only low element-width bits used
- i_valid  in  1  element valid
- o_ready  out  1  element accepted when i_valid & o_ready
- i_flush  in  1  pad and write partial word, end job (macro-dependent)
- o_write_en  out  1  SRAM write strobe
- o_write_addr  out  ADDR_WIDTH  SRAM write address
- o_data_out  out  SRAM_DATA_WIDTH  packed word
- o_sram_select  out  2  latched target
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle completion pulse
- o_last_addr  out  ADDR_WIDTH  address of last word written by the most recent job

## Operation
- States: IDLE, FILL, DONE.
- IDLE: o_ready=0. i_start with i_word_count=0 -> DONE directly, no writes. i_start otherwise -> latch config, address counter=i_base_addr, beat counter=0, -> FILL.
- FILL: o_ready=1 until the beat completing the final word is accepted, then 0. Each accepted beat writes its element into slot beat_count of the shift/pack register; slot 0 = bits [w-1:0]. Beats per word: 8/16/32 for 8b/4b/2b.
- Word completion: on the accepting edge of the last beat, the word, its address, and write strobe are registered; address counter increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00); words-remaining decrements; beat counter clears.
- After the final word's strobe is registered -> DONE.
- DONE: o_done=1 for one cycle, o_last_addr updated, -> IDLE.
- i_start outside IDLE ignored. Config inputs outside the start cycle ignored.
- Packing register cleared at each word start; unused upper bits of i_data ignored.

## Timing
- Reset values: o_ready=0, o_write_en=0, o_write_addr=0, o_data_out=0, o_sram_select=0, o_busy=0, o_done=0, o_last_addr=0; state IDLE.
- i_start at edge k -> FILL in cycle k+1, o_ready=1 and o_busy=1 from cycle k+1.
- Throughput: one element per cycle, no bubbles between words.
- Beat completing a word accepted at edge n -> o_write_en=1 during cycle n+1 only, with valid o_write_addr/o_data_out/o_sram_select.
- Final write in cycle n+1 -> o_done=1 in cycle n+2; o_busy=1 through cycle n+2, 0 from n+3. Zero-count job: o_done in cycle k+1.
- i_valid low stalls packing; no state change.
- i_rst mid-job: state IDLE next cycle, partial word discarded, no write strobe, all outputs to reset values.

## Configuration
- LOADER_FLUSH_EN defined: i_flush in FILL, sampled at edge f, has priority over a same-cycle beat (beat not accepted). If beat counter is nonzero, the partial word with zero-filled remaining slots is written at cycle f+1 and o_done follows in cycle f+2. If beat counter is zero, no write and o_done in cycle f+1. o_last_addr = last address actually written, unchanged if none.
- Undefined: i_flush ignored; jobs end only after i_word_count words.

## Test plan
- Mode 00, base 0x10, count 2, bytes 0x01..0x10 back-to-back -> writes 0x0807060504030201 @0x10, 0x100F0E0D0C0B0A09 @0x11 on consecutive strobes; o_done 1 cycle after second; o_last_addr=0x11.
- Mode 01, base 0, count 1, nibbles 1..F then 0 -> single write 0x0FEDCBA987654321 @0x00; 16 beats accepted.
- Mode 00, base 0xFF, count 2, i_valid toggling every other cycle -> writes @0xFF then @0x00, contents independent of gaps; o_last_addr=0x00.
- i_start, count 0 -> no o_write_en, o_done next cycle; i_start during FILL -> ignored, no latch change.
- LOADER_FLUSH_EN, mode 00, base 0x20, count 4, bytes AA BB CC then i_flush -> write 0x0000000000CCBBAA @0x20, o_done, o_last_addr=0x20; without macro, no write, o_busy stays 1.
- i_rst after 5 of 8 beats -> no write, all outputs 0 next cycle; new job then writes correctly from beat 0.

Source files
------------

// File: rtl/sram_loader.sv
// sram_loader: packs a narrow valid/ready element stream LSB-first into
// SRAM words and writes them at auto-incrementing addresses.
// Ports: i_clk/i_rst (sync, active-high); i_start + i_sram_select,
// i_base_addr, i_word_count, i_p_mode job config (latched at start);
// i_data/i_valid/o_ready element stream; i_flush partial-word end;
// o_write_en/o_write_addr/o_data_out/o_sram_select SRAM write port;
// o_busy, o_done pulse, o_last_addr of the last word written.
// Optional feature macro: LOADER_FLUSH_EN (enables i_flush).
module sram_loader #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [1:0]                 i_sram_select,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [ADDR_WIDTH:0]        i_word_count,
  input  logic [1:0]                 i_p_mode,
  input  logic [7:0]                 i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_flush,
  output logic                       o_write_en,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
  output logic [1:0]                 o_sram_select,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_WIDTH-1:0]      o_last_addr
);

  localparam int DW = SRAM_DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int BW = $clog2(DW / 2);
  localparam int SW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr_cnt, addr_n;
  logic [AW:0]   remaining, remaining_n;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [DW-1:0] pk, pk_n;
  logic [1:0]    mode, mode_n;
  logic          job_wrote, job_wrote_n;
  logic          we_n;
  logic [AW-1:0] waddr_n;
  logic [DW-1:0] data_n;
  logic [1:0]    sel_n;
  logic [AW-1:0] last_n;

  logic          fill_act;
  logic          flush_req;
  logic          accept;
  logic [7:0]    elem;
  logic [SW-1:0] sh;
  logic [BW-1:0] last_idx;
  logic          last_beat;
  logic [DW-1:0] pk_ins;

  // FILL with words still owed; FILL with none left is the
  // one-cycle wait that lets the final strobe land before DONE.
  assign fill_act = (state == FILL) && (remaining != '0);

`ifdef LOADER_FLUSH_EN
  assign flush_req = i_flush & fill_act;
`else
  // Flush disabled: input kept only for pin compatibility.
  assign flush_req = i_flush & 1'b0;
`endif

  // Flush wins over a same-cycle beat, so ready drops with it.
  assign o_ready = fill_act & ~flush_req;
  assign accept  = i_valid & o_ready;
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

  always_comb begin
    elem     = i_data;
    sh       = SW'(beat_cnt) << 3;
    last_idx = BW'(DW / 8 - 1);
    unique case (mode)
      2'b01: begin
        elem     = {4'b0, i_data[3:0]};
        sh       = SW'(beat_cnt) << 2;
        last_idx = BW'(DW / 4 - 1);
      end
      2'b10: begin
        elem     = {6'b0, i_data[1:0]};
        sh       = SW'(beat_cnt) << 1;
        last_idx = BW'(DW / 2 - 1);
      end
      default: ;
    endcase
  end

  assign last_beat = (beat_cnt == last_idx);
  assign pk_ins    = pk | (DW'(elem) << sh);

  always_comb begin
    state_n     = state;
    addr_n      = addr_cnt;
    remaining_n = remaining;
    beat_n      = beat_cnt;
    pk_n        = pk;
    mode_n      = mode;
    job_wrote_n = job_wrote;
    we_n        = 1'b0;
    waddr_n     = o_write_addr;
    data_n      = o_data_out;
    sel_n       = o_sram_select;
    last_n      = o_last_addr;

    unique case (state)
      IDLE: begin
        if (i_start) begin
          sel_n       = i_sram_select;
          mode_n      = (i_p_mode == 2'b11) ? 2'b00 : i_p_mode;
          job_wrote_n = 1'b0;
          if (i_word_count == '0) begin
            state_n = DONE;
          end else begin
            addr_n      = i_base_addr;
            remaining_n = i_word_count;
            beat_n      = '0;
            pk_n        = '0;
            state_n     = FILL;
          end
        end
      end
      FILL: begin
        if (flush_req) begin
          if (beat_cnt != '0) begin
            // Unfilled slots are already zero.
            we_n        = 1'b1;
            waddr_n     = addr_cnt;
            data_n      = pk;
            addr_n      = addr_cnt + AW'(1);
            remaining_n = '0;
            beat_n      = '0;
            pk_n        = '0;
            job_wrote_n = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else if (accept) begin
          if (last_beat) begin
            we_n        = 1'b1;
            waddr_n     = addr_cnt;
            data_n      = pk_ins;
            addr_n      = addr_cnt + AW'(1);
            remaining_n = remaining - (AW + 1)'(1);
            beat_n      = '0;
            pk_n        = '0;
            job_wrote_n = 1'b1;
          end else begin
            pk_n   = pk_ins;
            beat_n = beat_cnt + BW'(1);
          end
        end else if (remaining == '0) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Write address register still holds the last word written.
    if (state == FILL && state_n == DONE && job_wrote)
      last_n = o_write_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      addr_cnt      <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
      pk            <= '0;
      mode          <= 2'b00;
      job_wrote     <= 1'b0;
      o_write_en    <= 1'b0;
      o_write_addr  <= '0;
      o_data_out    <= '0;
      o_sram_select <= 2'b00;
      o_last_addr   <= '0;
    end else begin
      state         <= state_n;
      addr_cnt      <= addr_n;
      remaining     <= remaining_n;
      beat_cnt      <= beat_n;
      pk            <= pk_n;
      mode          <= mode_n;
      job_wrote     <= job_wrote_n;
      o_write_en    <= we_n;
      o_write_addr  <= waddr_n;
      o_data_out    <= data_n;
      o_sram_select <= sel_n;
      o_last_addr   <= last_n;
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: directed self-checking bench for sram_loader.
// Inputs driven 1 time unit after each rising edge; outputs read there.
module tb_sram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  sel_in;
  logic [7:0]  base;
  logic [8:0]  cnt;
  logic [1:0]  mode;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        flush;
  logic        wen;
  logic [7:0]  waddr;
  logic [63:0] dout;
  logic [1:0]  sel_out;
  logic        busy;
  logic        done;
  logic [7:0]  last;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [7:0]  la[$];
  logic [63:0] ld[$];

  sram_loader #(.SRAM_DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_sram_select(sel_in), .i_base_addr(base),
    .i_word_count(cnt), .i_p_mode(mode),
    .i_data(data), .i_valid(valid), .o_ready(ready),
    .i_flush(flush), .o_write_en(wen), .o_write_addr(waddr),
    .o_data_out(dout), .o_sram_select(sel_out),
    .o_busy(busy), .o_done(done), .o_last_addr(last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wen) begin
      la.push_back(waddr);
      ld.push_back(dout);
    end
    if (done) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    la.delete();
    ld.delete();
    done_seen = 0;
  endtask

  task automatic start_job(input logic [1:0] s, input logic [7:0] b,
                           input logic [8:0] c, input logic [1:0] m);
    start = 1'b1; sel_in = s; base = b; cnt = c; mode = m;
    tick;
    start = 1'b0; sel_in = 2'd3; base = 8'hEE;
    cnt = 9'h1FF; mode = 2'b10;
  endtask

  task automatic beat(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    tick;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b required 0", nm, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; sel_in = 0; base = 0; cnt = 0;
    mode = 0; data = 0; valid = 0; flush = 0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({ready, wen, waddr, dout, sel_out, busy, done, last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: r%b w%b a%h d%h s%h b%b dn%b l%h required all 0",
               ready, wen, waddr, dout, sel_out, busy, done, last);
    end
  endtask

  task automatic test_mode8;
    clear_log;
    start_job(2'd1, 8'h10, 9'd2, 2'b00);
    checks++;
    if ({ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL m8_start: ready=%b busy=%b required 1 1", ready, busy);
    end
    for (int i = 1; i <= 16; i++) begin
      beat(8'(i));
      if (i == 8) begin
        checks++;
        if ({wen, sel_out, waddr, dout} !== {1'b1, 2'd1, 8'h10, 64'h0807060504030201}) begin
          errors++;
          $display("FAIL m8_word0: w%b s%h a%h d%h required 1 1 10 0807060504030201",
                   wen, sel_out, waddr, dout);
        end
      end
    end
    checks++;
    if ({wen, sel_out, waddr, dout, ready} !== {1'b1, 2'd1, 8'h11, 64'h100F0E0D0C0B0A09, 1'b0}) begin
      errors++;
      $display("FAIL m8_word1: w%b s%h a%h d%h r%b required 1 1 11 100F0E0D0C0B0A09 0",
               wen, sel_out, waddr, dout, ready);
    end
    tick;
    checks++;
    if ({wen, done, busy} !== 3'b011) begin
      errors++;
      $display("FAIL m8_done: w%b done%b busy%b required 0 1 1", wen, done, busy);
    end
    tick;
    checks++;
    if ({done, busy, last} !== {2'b00, 8'h11}) begin
      errors++;
      $display("FAIL m8_end: done%b busy%b last%h required 0 0 11", done, busy, last);
    end
    checks++;
    if (la.size() != 2 || done_seen != 1) begin
      errors++;
      $display("FAIL m8_counts: writes=%0d dones=%0d required 2 1", la.size(), done_seen);
    end
  endtask

  task automatic test_zero_count;
    clear_log;
    start_job(2'd0, 8'h77, 9'd0, 2'b00);
    checks++;
    if ({done, busy, ready, wen} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_done: done%b busy%b ready%b wen%b required 1 1 0 0",
               done, busy, ready, wen);
    end
    tick;
    checks++;
    if ({done, busy, last} !== {2'b00, 8'h11} || la.size() != 0) begin
      errors++;
      $display("FAIL zero_end: done%b busy%b last%h writes=%0d required 0 0 11 0",
               done, busy, last, la.size());
    end
  endtask

  task automatic test_mode4;
    clear_log;
    start_job(2'd1, 8'h00, 9'd1, 2'b01);
    for (int i = 0; i < 16; i++) begin
      beat(8'hA0 | 8'((i + 1) & 15));
      if (i == 14) begin
        checks++;
        if (wen !== 1'b0) begin
          errors++;
          $display("FAIL m4_early: wen=%b after 15 beats required 0", wen);
        end
      end
    end
    checks++;
    if ({wen, waddr, dout, ready} !== {1'b1, 8'h00, 64'h0FEDCBA987654321, 1'b0}) begin
      errors++;
      $display("FAIL m4_word: w%b a%h d%h r%b required 1 00 0FEDCBA987654321 0",
               wen, waddr, dout, ready);
    end
    wait_idle("m4");
    checks++;
    if (last !== 8'h00 || la.size() != 1) begin
      errors++;
      $display("FAIL m4_last: last=%h writes=%0d required 00 1", last, la.size());
    end
  endtask

  task automatic test_wrap;
    clear_log;
    start_job(2'd0, 8'hFF, 9'd2, 2'b11);
    for (int i = 0; i < 16; i++) begin
      valid = 1'b0;
      data  = 8'h5A;
      tick;
      beat(8'h21 + 8'(i));
    end
    wait_idle("wrap");
    checks++;
    if (la.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d required 2", la.size());
    end else begin
      checks++;
      if ({la[0], ld[0], la[1], ld[1]} !==
          {8'hFF, 64'h2827262524232221, 8'h00, 64'h302F2E2D2C2B2A29}) begin
        errors++;
        $display("FAIL wrap_data: %h:%h %h:%h required FF:2827262524232221 00:302F2E2D2C2B2A29",
                 la[0], ld[0], la[1], ld[1]);
      end
    end
    checks++;
    if (last !== 8'h00 || done_seen != 1) begin
      errors++;
      $display("FAIL wrap_last: last=%h dones=%0d required 00 1", last, done_seen);
    end
  endtask

  task automatic test_start_ignored;
    clear_log;
    start_job(2'd1, 8'h40, 9'd1, 2'b00);
    for (int i = 1; i <= 3; i++) beat(8'(i));
    start = 1'b1; sel_in = 2'd2; base = 8'h80; cnt = 9'd0; mode = 2'b01;
    beat(8'h04);
    start = 1'b0;
    for (int i = 5; i <= 8; i++) beat(8'(i));
    checks++;
    if ({wen, sel_out, waddr, dout} !== {1'b1, 2'd1, 8'h40, 64'h0807060504030201}) begin
      errors++;
      $display("FAIL start_ignored: w%b s%h a%h d%h required 1 1 40 0807060504030201",
               wen, sel_out, waddr, dout);
    end
    wait_idle("start_ignored");
  endtask

  task automatic test_flush;
    clear_log;
    start_job(2'd0, 8'h20, 9'd4, 2'b00);
    beat(8'hAA); beat(8'hBB); beat(8'hCC);
`ifdef LOADER_FLUSH_EN
    flush = 1'b1; valid = 1'b1; data = 8'hDD;
    tick;
    flush = 1'b0; valid = 1'b0;
    checks++;
    if ({wen, sel_out, waddr, dout, ready} !== {1'b1, 2'd0, 8'h20, 64'h0000000000CCBBAA, 1'b0}) begin
      errors++;
      $display("FAIL flush_word: w%b s%h a%h d%h r%b required 1 0 20 0000000000CCBBAA 0",
               wen, sel_out, waddr, dout, ready);
    end
    tick;
    checks++;
    if ({done, wen} !== 2'b10) begin
      errors++;
      $display("FAIL flush_done: done%b wen%b required 1 0", done, wen);
    end
    tick;
    checks++;
    if ({busy, last} !== {1'b0, 8'h20}) begin
      errors++;
      $display("FAIL flush_last: busy%b last%h required 0 20", busy, last);
    end
    clear_log;
    start_job(2'd0, 8'h30, 9'd2, 2'b00);
    for (int i = 1; i <= 8; i++) beat(8'(i));
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++;
    if ({done, wen} !== 2'b10) begin
      errors++;
      $display("FAIL flush0_done: done%b wen%b required 1 0", done, wen);
    end
    tick;
    checks++;
    if ({busy, last} !== {1'b0, 8'h30} || la.size() != 1) begin
      errors++;
      $display("FAIL flush0_end: busy%b last%h writes=%0d required 0 30 1",
               busy, last, la.size());
    end
`else
    flush = 1'b1; valid = 1'b0;
    tick;
    flush = 1'b0;
    checks++;
    if ({wen, busy, ready} !== 3'b011) begin
      errors++;
      $display("FAIL noflush_state: wen%b busy%b ready%b required 0 1 1", wen, busy, ready);
    end
    repeat (3) tick;
    checks++;
    if (busy !== 1'b1 || la.size() != 0 || done_seen != 0) begin
      errors++;
      $display("FAIL noflush_hold: busy%b writes=%0d dones=%0d required 1 0 0",
               busy, la.size(), done_seen);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
`endif
  endtask

  task automatic test_reset_mid;
    clear_log;
    start_job(2'd1, 8'h50, 9'd1, 2'b00);
    for (int i = 1; i <= 5; i++) beat(8'(i));
    rst = 1'b1;
    tick;
    checks++;
    if ({ready, wen, waddr, dout, sel_out, busy, done, last} !== '0) begin
      errors++;
      $display("FAIL rst_mid: r%b w%b a%h d%h s%h b%b dn%b l%h required all 0",
               ready, wen, waddr, dout, sel_out, busy, done, last);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (la.size() != 0) begin
      errors++;
      $display("FAIL rst_nowrite: writes=%0d required 0", la.size());
    end
    start_job(2'd0, 8'h60, 9'd1, 2'b00);
    for (int i = 0; i < 8; i++) beat(8'h91 + 8'(i));
    checks++;
    if ({wen, sel_out, waddr, dout} !== {1'b1, 2'd0, 8'h60, 64'h9897969594939291}) begin
      errors++;
      $display("FAIL rst_rejob: w%b s%h a%h d%h required 1 0 60 9897969594939291",
               wen, sel_out, waddr, dout);
    end
    wait_idle("rst_rejob");
    checks++;
    if (last !== 8'h60) begin
      errors++;
      $display("FAIL rst_last: last=%h required 60", last);
    end
  endtask

  initial begin
    test_reset;
    test_mode8;
    test_zero_count;
    test_mode4;
    test_wrap;
    test_start_ignored;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
